// File: rtl/enemy_motion_ctrl.sv
// enemy_motion_ctrl
//   Owns position and visibility of the 10 on-screen enemies. On each
//   frame_tick every enemy is stepped down one at a time (one per cycle).
//   Enemies passing the bottom limit respawn at the top, hit kills are
//   applied, and then load_coord pulses once so the draw datapath can
//   capture a coherent coordinate set.
//
//   Optional feature macro: ENEMY_LFSR_SPAWN_EN
//     defined     : respawn x taken from an 8-bit LFSR, folded into 0..X_MAX
//     not defined : respawn x is the enemy's fixed reset lane; no LFSR
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   frame_tick  1-cycle pulse, starts one position update (ignored while busy)
//   hit_valid   1-cycle pulse, kill enemy hit_idx (10..15 ignored)
//   hit_idx     index of the killed enemy
//   x_bus       packed x coords, enemy i at [8i+7:8i]
//   y_bus       packed y coords, enemy i at [8i+7:8i]
//   visible     bit i = enemy i alive
//   load_coord  1-cycle pulse, buses are coherent and should be captured
//   busy        high during UPDATE and LOAD
//   escape_cnt  saturating count of visible enemies that reached the bottom
//
// state  | meaning
// IDLE   | waiting for frame_tick
// UPDATE | stepping enemy idx (0..9), one per cycle
// LOAD   | coordinates coherent, load_coord asserted
module enemy_motion_ctrl #(
    parameter int unsigned STEP      = 1,
    parameter int unsigned Y_LIMIT   = 115,
    parameter int unsigned X_MAX     = 150,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        hit_valid,
    input  logic [3:0]  hit_idx,
    output logic [79:0] x_bus,
    output logic [79:0] y_bus,
    output logic [9:0]  visible,
    output logic        load_coord,
    output logic        busy,
    output logic [7:0]  escape_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        LOAD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  x_q [10];
    logic [7:0]  y_q [10];
    logic [9:0]  vis_q;
    logic [7:0]  esc_q;
    logic [8:0]  y_next;
    logic        respawn;
    logic [7:0]  respawn_x;

    function automatic logic [7:0] lane_x(input logic [3:0] i);
        case (i)
            4'd0:    lane_x = 8'd102;
            4'd1:    lane_x = 8'd82;
            4'd2:    lane_x = 8'd62;
            4'd3:    lane_x = 8'd122;
            4'd4:    lane_x = 8'd72;
            4'd5:    lane_x = 8'd32;
            4'd6:    lane_x = 8'd42;
            4'd7:    lane_x = 8'd2;
            4'd8:    lane_x = 8'd12;
            4'd9:    lane_x = 8'd142;
            default: lane_x = 8'd0;
        endcase
    endfunction

    // 9-bit sum so an enemy near 255 can never wrap back onto the screen.
    always_comb begin
        y_next  = {1'b0, y_q[idx_q]} + 9'(STEP);
        respawn = (y_next > 9'(Y_LIMIT));
    end

`ifdef ENEMY_LFSR_SPAWN_EN
    logic [7:0] lfsr_q;

    // Fibonacci x^8+x^6+x^5+x^4+1, free running so spawn columns vary.
    always_ff @(posedge clk) begin
        if (!reset_n)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Single subtraction suffices: 255-(X_MAX+1) is already <= X_MAX.
    always_comb begin
        respawn_x = (lfsr_q > 8'(X_MAX)) ? (lfsr_q - 8'(X_MAX + 1)) : lfsr_q;
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;

    always_comb begin
        respawn_x = lane_x(idx_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            vis_q   <= 10'h3FF;
            esc_q   <= 8'd0;
            for (int i = 0; i < 10; i++) begin
                x_q[i] <= lane_x(4'(i));
                y_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (hit_valid && (hit_idx < 4'd10))
                vis_q[hit_idx] <= 1'b0;
            // Placed after the hit clear so a respawn in the same cycle wins.
            if (state_q == UPDATE) begin
                if (respawn) begin
                    y_q[idx_q]   <= 8'd0;
                    x_q[idx_q]   <= respawn_x;
                    vis_q[idx_q] <= 1'b1;
                    if (vis_q[idx_q] && (esc_q != 8'hFF))
                        esc_q <= esc_q + 8'd1;
                end else begin
                    y_q[idx_q] <= y_next[7:0];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        load_coord = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = 4'd0;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (idx_q == 4'd9) begin
                    state_d = LOAD;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                load_coord = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        x_bus = '0;
        y_bus = '0;
        for (int i = 0; i < 10; i++) begin
            x_bus[8*i +: 8] = x_q[i];
            y_bus[8*i +: 8] = y_q[i];
        end
    end

    assign visible    = vis_q;
    assign escape_cnt = esc_q;

endmodule
